// File: rtl/clk_div_bank_if.sv
// Configuration write bus for the clock divider bank.
// One write per cycle targets a single channel's shadow settings.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    output cfg_mode
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_div,
    input cfg_mode
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers with tick strobes.
// New settings are shadowed and applied only at a period boundary.
module clk_div_bank #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  clk_div_bank_if.slave     cfg,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pending
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_div  [NUM_CH];
  logic [CNT_W-1:0]  r_sdiv [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_smode;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_tick;

  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_bnd;

  always_comb begin
    w_wr  = '0;
    w_run = '0;
    w_bnd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i]  = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
      w_run[i] = i_ch_en[i] && (r_div[i] != '0);
      w_bnd[i] = w_run[i] &&
                 (r_cnt[i] == r_div[i] - CNT_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]  <= '0;
        r_div[i]  <= CNT_W'(DEFAULT_DIV);
        r_sdiv[i] <= '0;
      end
      r_mode  <= '0;
      r_smode <= '0;
      r_pend  <= '0;
      r_clk   <= '0;
      r_tick  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_run[i]) begin
          r_cnt[i]  <= '0;
          r_clk[i]  <= 1'b0;
          r_tick[i] <= 1'b0;
          // a fresh write while idle supersedes any queued one
          if (w_wr[i]) begin
            r_sdiv[i]  <= cfg.cfg_div;
            r_smode[i] <= cfg.cfg_mode;
            r_pend[i]  <= 1'b1;
          end else if (r_pend[i]) begin
            r_div[i]  <= r_sdiv[i];
            r_mode[i] <= r_smode[i];
            r_pend[i] <= 1'b0;
          end
        end else if (w_bnd[i]) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
          r_clk[i]  <= r_mode[i] ? 1'b1 : ~r_clk[i];
          if (w_wr[i]) begin
            r_div[i]  <= cfg.cfg_div;
            r_mode[i] <= cfg.cfg_mode;
            r_pend[i] <= 1'b0;
          end else if (r_pend[i]) begin
            r_div[i]  <= r_sdiv[i];
            r_mode[i] <= r_smode[i];
            r_pend[i] <= 1'b0;
          end
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
          if (r_mode[i]) r_clk[i] <= 1'b0;
          if (w_wr[i]) begin
            r_sdiv[i]  <= cfg.cfg_div;
            r_smode[i] <= cfg.cfg_mode;
            r_pend[i]  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_clk_out = r_clk;
  assign o_tick    = r_tick;
  assign o_pending = r_pend;
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank.
// Main bank uses 4 channels; a 3-channel bank covers out-of-range writes.
module tb_clk_div_bank;
  logic       clk;
  logic       reset;
  logic [3:0] ch_en;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] pending;
  logic [2:0] clk_out3;
  logic [2:0] tick3;
  logic [2:0] pending3;

  int n_chk;
  int n_pass;
  logic [3:0] acc;

  clk_div_bank_if #(.NUM_CH(4), .CNT_W(27)) cfg0 ();
  clk_div_bank_if #(.NUM_CH(3), .CNT_W(27)) cfg1 ();

  clk_div_bank #(.NUM_CH(4), .CNT_W(27), .DEFAULT_DIV(0)) u_dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .cfg       (cfg0),
    .i_ch_en   (ch_en),
    .o_clk_out (clk_out),
    .o_tick    (tick),
    .o_pending (pending)
  );

  clk_div_bank #(.NUM_CH(3), .CNT_W(27), .DEFAULT_DIV(0)) u_dut3 (
    .i_clk     (clk),
    .i_reset   (reset),
    .cfg       (cfg1),
    .i_ch_en   (3'b111),
    .o_clk_out (clk_out3),
    .o_tick    (tick3),
    .o_pending (pending3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic wr(input int ch, input int d, input logic m);
    cfg0.cfg_we   = 1'b1;
    cfg0.cfg_ch   = 2'(ch);
    cfg0.cfg_div  = 27'(d);
    cfg0.cfg_mode = m;
    step();
    cfg0.cfg_we   = 1'b0;
  endtask

  task automatic wr3(input int ch, input int d);
    cfg1.cfg_we   = 1'b1;
    cfg1.cfg_ch   = 2'(ch);
    cfg1.cfg_div  = 27'(d);
    cfg1.cfg_mode = 1'b0;
    step();
    cfg1.cfg_we   = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    ch_en = '0;
    cfg0.cfg_we = 1'b0;
    cfg0.cfg_ch = '0;
    cfg0.cfg_div = '0;
    cfg0.cfg_mode = 1'b0;
    cfg1.cfg_we = 1'b0;
    cfg1.cfg_ch = '0;
    cfg1.cfg_div = '0;
    cfg1.cfg_mode = 1'b0;
    step();
    step();
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pend", 32'(pending), 0);

    // zero clock: default divide 0 keeps everything low
    reset = 1'b0;
    ch_en = 4'hF;
    acc = '0;
    for (int k = 0; k < 200; k++) begin
      step();
      acc = acc | clk_out | tick | pending;
    end
    chk("zero_clk", 32'(acc), 0);

    // ch0 D=4 toggle
    ch_en = 4'b0000;
    wr(0, 4, 1'b0);
    chk("c0_pend_set", 32'(pending[0]), 1);
    step();
    chk("c0_pend_clr", 32'(pending[0]), 0);
    ch_en = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("c0_tick_k%0d", k), 32'(tick[0]),
          32'(k % 4 == 0));
      chk($sformatf("c0_clk_k%0d", k), 32'(clk_out[0]),
          32'((k / 4) % 2));
    end

    // ch1 D=3 pulse, then D=1 toggle
    wr(1, 3, 1'b1);
    step();
    ch_en = 4'b0011;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("c1_tick_k%0d", k), 32'(tick[1]),
          32'(k % 3 == 0));
      chk($sformatf("c1_clk_k%0d", k), 32'(clk_out[1]),
          32'(k % 3 == 0));
    end
    wr(1, 1, 1'b0);
    chk("c1_pend", 32'(pending[1]), 1);
    step();
    step();
    chk("c1_bnd_tick", 32'(tick[1]), 1);
    chk("c1_bnd_clk", 32'(clk_out[1]), 1);
    chk("c1_bnd_pend", 32'(pending[1]), 0);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("c1_d1_tick_%0d", j), 32'(tick[1]), 1);
      chk($sformatf("c1_d1_clk_%0d", j), 32'(clk_out[1]),
          32'(j % 2 == 0));
    end

    // ch2 D=5, rewrite to D=2 mid-period, then boundary write
    ch_en = 4'b0011;
    wr(2, 5, 1'b0);
    step();
    ch_en = 4'b0111;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("c2_tick_k%0d", k), 32'(tick[2]),
          32'(k == 5));
    end
    wr(2, 2, 1'b0);
    chk("c2_pend_k7", 32'(pending[2]), 1);
    step();
    chk("c2_pend_k8", 32'(pending[2]), 1);
    step();
    chk("c2_pend_k9", 32'(pending[2]), 1);
    step();
    chk("c2_tick_k10", 32'(tick[2]), 1);
    chk("c2_pend_k10", 32'(pending[2]), 0);
    for (int k = 11; k <= 15; k++) begin
      step();
      chk($sformatf("c2_d2_tick_k%0d", k), 32'(tick[2]),
          32'(k % 2 == 0));
    end
    wr(2, 3, 1'b0);
    chk("c2_bw_tick", 32'(tick[2]), 1);
    chk("c2_bw_pend", 32'(pending[2]), 0);
    step();
    chk("c2_bw_t17", 32'(tick[2]), 0);
    chk("c2_bw_p17", 32'(pending[2]), 0);
    step();
    chk("c2_bw_t18", 32'(tick[2]), 0);
    step();
    chk("c2_bw_t19", 32'(tick[2]), 1);

    // ch3 D=6, drop enable mid-period, re-enable
    wr(3, 6, 1'b0);
    step();
    ch_en = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 6) begin
        chk("c3_tick_k6", 32'(tick[3]), 1);
        chk("c3_clk_k6", 32'(clk_out[3]), 1);
      end
    end
    ch_en = 4'b0111;
    step();
    chk("c3_off_clk", 32'(clk_out[3]), 0);
    chk("c3_off_tick", 32'(tick[3]), 0);
    step();
    ch_en = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("c3_re_tick_%0d", k), 32'(tick[3]),
          32'(k == 6));
      chk($sformatf("c3_re_clk_%0d", k), 32'(clk_out[3]),
          32'(k == 6));
    end

    // reset mid-period
    step();
    step();
    reset = 1'b1;
    step();
    chk("mrst_clk", 32'(clk_out), 0);
    chk("mrst_tick", 32'(tick), 0);
    chk("mrst_pend", 32'(pending), 0);
    reset = 1'b0;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      acc = acc | clk_out | tick;
    end
    chk("mrst_div0", 32'(acc), 0);

    // out-of-range channel on the 3-channel bank
    wr3(3, 2);
    chk("oor_pend", 32'(pending3), 0);
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      acc[2:0] = acc[2:0] | clk_out3 | tick3 | pending3;
    end
    chk("oor_quiet", 32'(acc), 0);
    wr3(2, 2);
    chk("inr_pend", 32'(pending3), 32'h4);

    // two writes while pending: last wins
    ch_en = 4'b0000;
    wr(0, 4, 1'b0);
    step();
    ch_en = 4'b0001;
    for (int k = 1; k <= 4; k++) step();
    chk("lw_tick_k4", 32'(tick[0]), 1);
    wr(0, 7, 1'b0);
    wr(0, 9, 1'b0);
    chk("lw_pend", 32'(pending[0]), 1);
    step();
    step();
    chk("lw_tick_k8", 32'(tick[0]), 1);
    chk("lw_pend_k8", 32'(pending[0]), 0);
    for (int k = 9; k <= 26; k++) begin
      step();
      chk($sformatf("lw_tick_k%0d", k), 32'(tick[0]),
          32'(k == 17 || k == 26));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
